// File: rtl/pci_pa_count_mx.sv
// PCIe CQ/CC performance-analysis counter bank with a snapshot shadow bank and indexed read port.
// Optional descriptor dword accumulators are built when PA_DWORD_COUNT_EN is defined.
module pci_pa_count_mx #(
  parameter int unsigned C_DATA_WIDTH = 512,
  parameter int unsigned COUNT_WIDTH  = 32,
  parameter bit          SATURATE     = 1'b1
) (
  input  logic                    user_clk,
  input  logic                    reset_n,
  input  logic                    m_axis_req_mon_tvalid,
  input  logic                    m_axis_req_mon_tready,
  input  logic                    m_axis_req_mon_tlast,
  input  logic [C_DATA_WIDTH-1:0] m_axis_req_mon_tdata,
  input  logic                    s_axis_cmp_mon_tvalid,
  input  logic                    s_axis_cmp_mon_tready,
  input  logic                    s_axis_cmp_mon_tlast,
  input  logic [C_DATA_WIDTH-1:0] s_axis_cmp_mon_tdata,
  input  logic                    pa_count_reset,
  input  logic                    pa_count_enable,
  input  logic                    pa_snapshot,
  input  logic [5:0]              rd_sel,
  output logic [COUNT_WIDTH-1:0]  rd_data,
  output logic                    pa_overflow
);

  localparam int unsigned NumCnt = 17;
  typedef logic [COUNT_WIDTH-1:0] cnt_t;

  logic        cq_vld_q, cq_rdy_q, cq_last_q, cq_sop_flag_q, cq_s1_q, cq_stb_q, cq_hs;
  logic [3:0]  cq_type_q, cq_type1_q, cq_type2_q;
  logic [10:0] cq_dw_q, cq_dw1_q, cq_dw2_q;
  logic        cc_vld_q, cc_rdy_q, cc_last_q, cc_sop_flag_q, cc_s1_q, cc_stb_q, cc_hs;
  logic [10:0] cc_dw_q, cc_dw1_q, cc_dw2_q;

  // Only the header fields are consumed; the rest of tdata is intentionally ignored.
  logic unused_tdata;
  assign unused_tdata = ^{m_axis_req_mon_tdata, s_axis_cmp_mon_tdata};

  assign cq_hs = cq_vld_q & cq_rdy_q;
  assign cc_hs = cc_vld_q & cc_rdy_q;

  // Input flops, SOP tracking, then a qualified stage; the extra s1 flop sets the 3-edge latency.
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      cq_vld_q <= 1'b0; cq_rdy_q <= 1'b0; cq_last_q <= 1'b0;
      cq_type_q <= '0; cq_dw_q <= '0; cq_sop_flag_q <= 1'b1;
      cq_s1_q <= 1'b0; cq_type1_q <= '0; cq_dw1_q <= '0;
      cq_stb_q <= 1'b0; cq_type2_q <= '0; cq_dw2_q <= '0;
      cc_vld_q <= 1'b0; cc_rdy_q <= 1'b0; cc_last_q <= 1'b0;
      cc_dw_q <= '0; cc_sop_flag_q <= 1'b1;
      cc_s1_q <= 1'b0; cc_dw1_q <= '0; cc_stb_q <= 1'b0; cc_dw2_q <= '0;
    end else begin
      cq_vld_q  <= m_axis_req_mon_tvalid;
      cq_rdy_q  <= m_axis_req_mon_tready;
      cq_last_q <= m_axis_req_mon_tlast;
      cq_type_q <= m_axis_req_mon_tdata[78:75];
      cq_dw_q   <= m_axis_req_mon_tdata[74:64];
      cc_vld_q  <= s_axis_cmp_mon_tvalid;
      cc_rdy_q  <= s_axis_cmp_mon_tready;
      cc_last_q <= s_axis_cmp_mon_tlast;
      cc_dw_q   <= s_axis_cmp_mon_tdata[42:32];

      if (cq_hs) cq_sop_flag_q <= cq_last_q;
      if (cc_hs) cc_sop_flag_q <= cc_last_q;
      cq_s1_q    <= cq_hs & cq_sop_flag_q;
      cq_type1_q <= cq_type_q;
      cq_dw1_q   <= cq_dw_q;
      cc_s1_q    <= cc_hs & cc_sop_flag_q;
      cc_dw1_q   <= cc_dw_q;

      cq_stb_q <= cq_s1_q;
      cc_stb_q <= cc_s1_q;
      if (cq_s1_q) begin
        cq_type2_q <= cq_type1_q;
        cq_dw2_q   <= cq_dw1_q;
      end
      if (cc_s1_q) cc_dw2_q <= cc_dw1_q;
    end
  end

  // Returns {overflow, result} under the configured saturate/wrap policy.
  function automatic logic [COUNT_WIDTH:0] acc(input cnt_t a, input cnt_t b);
    logic [COUNT_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (SATURATE) begin
      if (sum[COUNT_WIDTH]) sum[COUNT_WIDTH-1:0] = '1;
      sum[COUNT_WIDTH] = &sum[COUNT_WIDTH-1:0];
    end
    return sum;
  endfunction

  cnt_t live_q [NumCnt];
  cnt_t live_d [NumCnt];
  cnt_t shadow_q [NumCnt];
  logic ovf_hit;
  cnt_t rd_d;
  cnt_t one;
  assign one = cnt_t'(1);

`ifdef PA_DWORD_COUNT_EN
  cnt_t dw_live_q [NumCnt];
  cnt_t dw_live_d [NumCnt];
  cnt_t dw_shadow_q [NumCnt];
  cnt_t cq_dw_ext, cc_dw_ext;
  assign cq_dw_ext = cnt_t'(cq_dw2_q);
  assign cc_dw_ext = cnt_t'(cc_dw2_q);
`else
  logic unused_dw;
  assign unused_dw = ^{cq_dw2_q, cc_dw2_q};
`endif

  always_comb begin
    logic [COUNT_WIDTH:0] t;
    t       = '0;
    live_d  = live_q;
    ovf_hit = 1'b0;
`ifdef PA_DWORD_COUNT_EN
    dw_live_d = dw_live_q;
`endif
    for (int i = 0; i < 16; i++) begin
      if (cq_stb_q && cq_type2_q == 4'(i)) begin
        t         = acc(live_q[i], one);
        live_d[i] = t[COUNT_WIDTH-1:0];
        ovf_hit   = ovf_hit | t[COUNT_WIDTH];
`ifdef PA_DWORD_COUNT_EN
        t            = acc(dw_live_q[i], cq_dw_ext);
        dw_live_d[i] = t[COUNT_WIDTH-1:0];
        ovf_hit      = ovf_hit | t[COUNT_WIDTH];
`endif
      end
    end
    if (cc_stb_q) begin
      t          = acc(live_q[16], one);
      live_d[16] = t[COUNT_WIDTH-1:0];
      ovf_hit    = ovf_hit | t[COUNT_WIDTH];
`ifdef PA_DWORD_COUNT_EN
      t             = acc(dw_live_q[16], cc_dw_ext);
      dw_live_d[16] = t[COUNT_WIDTH-1:0];
      ovf_hit       = ovf_hit | t[COUNT_WIDTH];
`endif
    end
  end

  // Index bit 5 selects the dword bank; low bits 0..16 address a counter.
  always_comb begin
    rd_d = '0;
    if (rd_sel[4:0] <= 5'd16) begin
      if (!rd_sel[5]) rd_d = shadow_q[rd_sel[4:0]];
`ifdef PA_DWORD_COUNT_EN
      else rd_d = dw_shadow_q[rd_sel[4:0]];
`endif
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      live_q      <= '{default: '0};
      shadow_q    <= '{default: '0};
`ifdef PA_DWORD_COUNT_EN
      dw_live_q   <= '{default: '0};
      dw_shadow_q <= '{default: '0};
`endif
      pa_overflow <= 1'b0;
      rd_data     <= '0;
    end else begin
      if (pa_snapshot) begin
        shadow_q    <= live_q;
`ifdef PA_DWORD_COUNT_EN
        dw_shadow_q <= dw_live_q;
`endif
      end
      if (pa_count_reset) begin
        live_q      <= '{default: '0};
`ifdef PA_DWORD_COUNT_EN
        dw_live_q   <= '{default: '0};
`endif
        pa_overflow <= 1'b0;
      end else if (pa_count_enable) begin
        live_q      <= live_d;
`ifdef PA_DWORD_COUNT_EN
        dw_live_q   <= dw_live_d;
`endif
        pa_overflow <= pa_overflow | ovf_hit;
      end
      rd_data <= rd_d;
    end
  end

endmodule

// File: tb/tb_pci_pa_count_mx.sv
// Scoreboard bench for pci_pa_count_mx: a saturating and a wrapping 16-bit instance share stimulus.
module tb_pci_pa_count_mx;

`ifdef PA_DWORD_COUNT_EN
  localparam bit DwEn = 1'b1;
`else
  localparam bit DwEn = 1'b0;
`endif

  logic         user_clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_tvalid = 1'b0, req_tready = 1'b1, req_tlast = 1'b0;
  logic [511:0] req_tdata = '0;
  logic         cmp_tvalid = 1'b0, cmp_tready = 1'b1, cmp_tlast = 1'b0;
  logic [511:0] cmp_tdata = '0;
  logic         pa_count_reset = 1'b0, pa_count_enable = 1'b1, pa_snapshot = 1'b0;
  logic [5:0]   rd_sel = '0;
  logic [15:0]  rd_data_s, rd_data_w;
  logic         ovf_s, ovf_w;

  always #5 user_clk = ~user_clk;

  pci_pa_count_mx #(.C_DATA_WIDTH(512), .COUNT_WIDTH(16), .SATURATE(1'b1)) dut_s (
    .user_clk(user_clk), .reset_n(reset_n),
    .m_axis_req_mon_tvalid(req_tvalid), .m_axis_req_mon_tready(req_tready),
    .m_axis_req_mon_tlast(req_tlast), .m_axis_req_mon_tdata(req_tdata),
    .s_axis_cmp_mon_tvalid(cmp_tvalid), .s_axis_cmp_mon_tready(cmp_tready),
    .s_axis_cmp_mon_tlast(cmp_tlast), .s_axis_cmp_mon_tdata(cmp_tdata),
    .pa_count_reset(pa_count_reset), .pa_count_enable(pa_count_enable),
    .pa_snapshot(pa_snapshot), .rd_sel(rd_sel), .rd_data(rd_data_s), .pa_overflow(ovf_s)
  );

  pci_pa_count_mx #(.C_DATA_WIDTH(512), .COUNT_WIDTH(16), .SATURATE(1'b0)) dut_w (
    .user_clk(user_clk), .reset_n(reset_n),
    .m_axis_req_mon_tvalid(req_tvalid), .m_axis_req_mon_tready(req_tready),
    .m_axis_req_mon_tlast(req_tlast), .m_axis_req_mon_tdata(req_tdata),
    .s_axis_cmp_mon_tvalid(cmp_tvalid), .s_axis_cmp_mon_tready(cmp_tready),
    .s_axis_cmp_mon_tlast(cmp_tlast), .s_axis_cmp_mon_tdata(cmp_tdata),
    .pa_count_reset(pa_count_reset), .pa_count_enable(pa_count_enable),
    .pa_snapshot(pa_snapshot), .rd_sel(rd_sel), .rd_data(rd_data_w), .pa_overflow(ovf_w)
  );

  typedef struct {
    logic [5:0]  sel;
    logic [15:0] es;
    logic [15:0] ew;
    logic        eo;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic rd_req = 1'b0;
  logic rd_req_q = 1'b0;

  always @(posedge user_clk) rd_req_q <= rd_req;

  task automatic check(input string name, input int sel, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s idx=%0d actual=0x%0h required=0x%0h", name, sel, act, exp);
    end
  endtask

  // Monitor: compares whenever a read request reaches its sampling point.
  always @(negedge user_clk) begin
    if (rd_req_q) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty actual=0 required=1");
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rd_data_sat", int'(e.sel), int'(rd_data_s), int'(e.es));
        check("rd_data_wrap", int'(e.sel), int'(rd_data_w), int'(e.ew));
        check("overflow_sat", int'(e.sel), int'(ovf_s), int'(e.eo));
        check("overflow_wrap", int'(e.sel), int'(ovf_w), int'(e.eo));
      end
    end
  end

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  task automatic drive(input logic cqv, input logic [3:0] t, input logic [10:0] cqdw,
                       input logic cql, input logic ccv, input logic [10:0] ccdw,
                       input logic ccl);
    req_tvalid = cqv;
    req_tlast  = cql;
    req_tdata  = '0;
    req_tdata[78:75] = t;
    req_tdata[74:64] = cqdw;
    cmp_tvalid = ccv;
    cmp_tlast  = ccl;
    cmp_tdata  = '0;
    cmp_tdata[42:32] = ccdw;
    step();
  endtask

  task automatic idle(input int n);
    req_tvalid = 1'b0;
    cmp_tvalid = 1'b0;
    repeat (n) step();
  endtask

  task automatic snapshot();
    pa_snapshot = 1'b1;
    step();
    pa_snapshot = 1'b0;
  endtask

  // rd_sel is held two edges before sampling so either read-latency reading holds.
  task automatic read(input int sel, input int es, input int ew, input logic eo);
    exp_t e;
    rd_sel = 6'(sel);
    step();
    e.sel = 6'(sel); e.es = 16'(es); e.ew = 16'(ew); e.eo = eo;
    q.push_back(e);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 64; i++) read(i, 0, 0, 1'b0);

    // Three single-beat MemWr, two three-beat MemRd; non-SOP beats carry decoy type 5.
    for (int i = 0; i < 3; i++) drive(1, 4'd1, 11'd4, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(1, 4'd0, 11'd4, 0, 0, 0, 0);
      drive(1, 4'd5, 11'd7, 0, 0, 0, 0);
      drive(1, 4'd5, 11'd7, 1, 0, 0, 0);
    end
    idle(6);
    snapshot();
    read(1, 3, 3, 1'b0);
    read(0, 2, 2, 1'b0);
    read(5, 0, 0, 1'b0);
    read(33, DwEn ? 12 : 0, DwEn ? 12 : 0, 1'b0);
    read(32, DwEn ? 8 : 0, DwEn ? 8 : 0, 1'b0);
    read(37, 0, 0, 1'b0);

    // Simultaneous CQ and CC SOP beats every cycle.
    for (int i = 0; i < 10; i++) drive(1, 4'd2, 11'd1, 1, 1, 11'd3, 1);
    idle(6);
    snapshot();
    read(2, 10, 10, 1'b0);
    read(16, 10, 10, 1'b0);
    read(34, DwEn ? 10 : 0, DwEn ? 10 : 0, 1'b0);
    read(48, DwEn ? 30 : 0, DwEn ? 30 : 0, 1'b0);
    read(1, 3, 3, 1'b0);

    // Counting disabled over the SOP, enabled mid-packet; trailing beats carry decoy type 9.
    pa_count_enable = 1'b0;
    drive(1, 4'd3, 11'd2, 0, 0, 0, 0);
    drive(1, 4'd3, 11'd2, 0, 0, 0, 0);
    idle(5);
    pa_count_enable = 1'b1;
    drive(1, 4'd9, 11'd5, 0, 0, 0, 0);
    drive(1, 4'd9, 11'd5, 1, 0, 0, 0);
    drive(1, 4'd3, 11'd2, 1, 0, 0, 0);
    idle(6);
    snapshot();
    read(3, 1, 1, 1'b0);
    read(9, 0, 0, 1'b0);
    read(35, DwEn ? 2 : 0, DwEn ? 2 : 0, 1'b0);
    read(41, 0, 0, 1'b0);

    // Completion flood: 10 + 65527 = 65537 events past a 16-bit counter.
    for (int i = 0; i < 65527; i++) drive(0, 4'd0, 11'd0, 0, 1, 11'd0, 1);
    idle(6);
    snapshot();
    read(16, 16'hFFFF, 16'h0001, 1'b1);
    read(48, DwEn ? 30 : 0, DwEn ? 30 : 0, 1'b1);

    // Bring idx0 to 5, then clear and snapshot on the same edge.
    for (int i = 0; i < 3; i++) drive(1, 4'd0, 11'd4, 1, 0, 0, 0);
    idle(6);
    pa_count_reset = 1'b1;
    pa_snapshot = 1'b1;
    step();
    pa_count_reset = 1'b0;
    pa_snapshot = 1'b0;
    read(0, 5, 5, 1'b0);
    read(16, 16'hFFFF, 16'h0001, 1'b0);
    read(32, DwEn ? 20 : 0, DwEn ? 20 : 0, 1'b0);
    snapshot();
    read(0, 0, 0, 1'b0);
    read(16, 0, 0, 1'b0);
    read(1, 0, 0, 1'b0);
    read(32, 0, 0, 1'b0);

    idle(2);
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
